// File: rtl/byte_packer_if.sv
// Byte-stream handshake in, packed lane word out, between the framer and the lane striper.
interface byte_packer_if #(
    parameter int numlanes = 4
);
    logic [7:0]            in_data;
    logic                  in_valid;
    logic                  in_last;
    logic                  in_ready;
    logic [numlanes*8-1:0] out_data;
    logic [numlanes-1:0]   out_k;
    logic                  out_valid;
    logic                  out_sof;
    logic                  out_eof;

    modport master (
        output in_data, in_valid, in_last,
        input  in_ready, out_data, out_k, out_valid, out_sof, out_eof
    );

    modport slave (
        input  in_data, in_valid, in_last,
        output in_ready, out_data, out_k, out_valid, out_sof, out_eof
    );
endinterface

// File: rtl/byte_packer.sv
// Packs numlanes framed bytes per word (lane 0 in the MSB), pads short tails with K23.7,
// emits K28.5 idle words otherwise and holds off input for ifg cycles after each frame.
module byte_packer #(
    parameter int numlanes = 4,
    parameter int ifg      = 2
) (
    input  logic         clk_1G,
    input  logic         rst_1G,
    byte_packer_if.slave bus
);
    localparam int W  = numlanes * 8;
    localparam int CW = $clog2(numlanes);
    localparam int GW = $clog2(ifg + 1);

    localparam logic [7:0]    IDLE_CH   = 8'hBC;
    localparam logic [7:0]    PAD_CH    = 8'hF7;
    localparam logic [CW-1:0] LAST_LANE = CW'(numlanes - 1);
    localparam logic [GW-1:0] GAP_END   = GW'(ifg - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_PACK = 2'd1;
    localparam logic [1:0] ST_GAP  = 2'd2;

    logic [1:0]          r_state;
    logic [CW-1:0]       r_cnt;
    logic [GW-1:0]       r_gap;
    logic                r_alive;
    logic                r_first;
    logic [W-1:0]        r_word;
    logic [W-1:0]        r_out_data;
    logic [numlanes-1:0] r_out_k;
    logic                r_out_valid;
    logic                r_out_sof;
    logic                r_out_eof;

    logic [W-1:0]        w_next_word;
    logic [numlanes-1:0] w_pad_k;
    logic                w_accept;
    logic                w_full;
    logic                w_sof;

    // r_alive keeps in_ready low until the first edge after reset release
    assign bus.in_ready = r_alive && (r_state != ST_GAP);
    assign w_accept     = bus.in_valid && bus.in_ready;
    assign w_full       = (r_cnt == LAST_LANE);
    assign w_sof        = (r_state == ST_IDLE) || r_first;

    // Lanes above the write pointer read as pad, so a last byte yields the padded word directly
    for (genvar g = 0; g < numlanes; g++) begin : g_lane
        localparam logic [CW-1:0] LANE = CW'(g);
        localparam int            LO   = (numlanes - 1 - g) * 8;
        assign w_next_word[LO +: 8] = (LANE == r_cnt) ? bus.in_data :
                                      (LANE >  r_cnt) ? PAD_CH : r_word[LO +: 8];
        assign w_pad_k[numlanes-1-g] = (LANE > r_cnt);
    end

    always_ff @(posedge clk_1G or negedge rst_1G) begin
        if (!rst_1G) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_gap       <= '0;
            r_alive     <= 1'b0;
            r_first     <= 1'b0;
            r_word      <= '0;
            r_out_data  <= {numlanes{IDLE_CH}};
            r_out_k     <= '1;
            r_out_valid <= 1'b0;
            r_out_sof   <= 1'b0;
            r_out_eof   <= 1'b0;
        end else begin
            r_alive     <= 1'b1;
            r_out_data  <= {numlanes{IDLE_CH}};
            r_out_k     <= '1;
            r_out_valid <= 1'b0;
            r_out_sof   <= 1'b0;
            r_out_eof   <= 1'b0;
            case (r_state)
                ST_IDLE, ST_PACK: begin
                    if (w_accept) begin
                        r_word <= w_next_word;
                        if (bus.in_last || w_full) begin
                            r_out_valid <= 1'b1;
                            r_out_data  <= w_next_word;
                            r_out_k     <= w_pad_k;
                            r_out_sof   <= w_sof;
                            r_out_eof   <= bus.in_last;
                            r_first     <= 1'b0;
                            r_cnt       <= '0;
                        end else begin
                            r_first <= w_sof;
                            r_cnt   <= r_cnt + 1'b1;
                        end
                        if (bus.in_last) begin
                            r_state <= ST_GAP;
                            r_gap   <= '0;
                        end else begin
                            r_state <= ST_PACK;
                        end
                    end
                end
                ST_GAP: begin
                    if (r_gap == GAP_END) begin
                        r_state <= ST_IDLE;
                        r_gap   <= '0;
                    end else begin
                        r_gap <= r_gap + 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.out_data  = r_out_data;
    assign bus.out_k     = r_out_k;
    assign bus.out_valid = r_out_valid;
    assign bus.out_sof   = r_out_sof;
    assign bus.out_eof   = r_out_eof;
endmodule

// File: tb/tb_byte_packer.sv
// Randomized and directed frames against a frame-to-word reference model; every output
// cycle is checked, plus reset behaviour and the inter-frame gap length.
module tb_byte_packer;
    localparam int N   = 4;
    localparam int IFG = 2;
    localparam logic [7:0] PAD = 8'hF7;
    localparam logic [N*8-1:0] IDLE_WORD = {N{8'hBC}};
    localparam logic [N-1:0]   ALL_K     = '1;

    typedef logic [7:0] bq_t[$];
    typedef struct packed {
        logic [N*8-1:0] d;
        logic [N-1:0]   k;
        logic           sof;
        logic           eof;
    } word_t;

    logic clk;
    logic rst_n;
    bit   mon_en;
    int   n_tests;
    int   n_fail;
    word_t exp_q[$];

    byte_packer_if #(.numlanes(N)) bus ();

    byte_packer #(.numlanes(N), .ifg(IFG)) dut (
        .clk_1G (clk),
        .rst_1G (rst_n),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: chop the frame into N-byte words, pad the tail, flag first/last word
    task automatic model_frame(input bq_t b);
        int nw;
        word_t e;
        nw = (b.size() + N - 1) / N;
        for (int w = 0; w < nw; w++) begin
            e = '0;
            for (int l = 0; l < N; l++) begin
                e.d = e.d << 8;
                e.k = e.k << 1;
                if (w * N + l < b.size()) begin
                    e.d[7:0] = b[w * N + l];
                end else begin
                    e.d[7:0] = PAD;
                    e.k[0]   = 1'b1;
                end
            end
            e.sof = (w == 0);
            e.eof = (w == nw - 1);
            exp_q.push_back(e);
        end
    endtask

    always @(negedge clk) begin
        word_t e;
        if (mon_en) begin
            if (bus.out_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("unexp_word", bus.out_valid, 1'b0);
                end else begin
                    e = exp_q.pop_front();
                    check("word_data", bus.out_data, e.d);
                    check("word_k", bus.out_k, e.k);
                    check("word_sof", bus.out_sof, e.sof);
                    check("word_eof", bus.out_eof, e.eof);
                end
            end else begin
                check("idle_data", bus.out_data, IDLE_WORD);
                check("idle_k", bus.out_k, ALL_K);
                check("idle_flags", {bus.out_sof, bus.out_eof}, 2'b00);
            end
        end
    end

    task automatic send_frame(input bq_t b, input int gap_lo, input int gap_hi, input bit term);
        int t;
        int g;
        int n_low;
        if (term) model_frame(b);
        for (int i = 0; i < b.size(); i++) begin
            g = int'($urandom_range(gap_hi, gap_lo));
            repeat (g) begin
                @(negedge clk);
                bus.in_valid = 1'b0;
                bus.in_last  = 1'b0;
            end
            @(negedge clk);
            bus.in_valid = 1'b1;
            bus.in_data  = b[i];
            bus.in_last  = term && (i == b.size() - 1);
            t = 0;
            while (bus.in_ready !== 1'b1 && t < 50) begin
                @(negedge clk);
                t++;
            end
            if (t >= 50) check("ready_timeout", bus.in_ready, 1'b1);
        end
        if (term) begin
            // Junk bytes offered during the gap must be ignored
            n_low = 0;
            for (int k = 0; k < 50; k++) begin
                @(negedge clk);
                if (bus.in_ready === 1'b1) break;
                bus.in_valid = 1'b1;
                bus.in_data  = 8'hEE;
                bus.in_last  = 1'($urandom);
                n_low++;
            end
            bus.in_valid = 1'b0;
            bus.in_last  = 1'b0;
            check("ifg_len", n_low, IFG);
        end else begin
            @(negedge clk);
            bus.in_valid = 1'b0;
            bus.in_last  = 1'b0;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_data"}, bus.out_data, IDLE_WORD);
        check({tag, "_k"}, bus.out_k, ALL_K);
        check({tag, "_valid"}, bus.out_valid, 1'b0);
        check({tag, "_ready"}, bus.in_ready, 1'b0);
    endtask

    initial begin
        bq_t f;
        int len;
        clk          = 1'b0;
        rst_n        = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.in_last  = 1'b0;
        n_tests      = 0;
        n_fail       = 0;
        mon_en       = 1'b0;
        #1 rst_n = 1'b0;
        #1 check_reset_outputs("rst0");
        mon_en = 1'b1;
        repeat (3) @(negedge clk);
        check("rdy_in_reset", bus.in_ready, 1'b0);
        rst_n = 1'b1;
        #1 check("rdy_before_edge", bus.in_ready, 1'b0);
        @(posedge clk);
        #1 check("rdy_after_edge", bus.in_ready, 1'b1);

        f = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
        send_frame(f, 0, 0, 1'b1);
        f = '{8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5};
        send_frame(f, 0, 0, 1'b1);
        f = '{8'h3C};
        send_frame(f, 0, 0, 1'b1);
        f = '{8'h11, 8'h22, 8'h33, 8'h44};
        send_frame(f, 3, 3, 1'b1);

        f = '{8'hDE, 8'hAD};
        send_frame(f, 0, 0, 1'b0);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("rst_mid");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        f = '{8'h55, 8'h66, 8'h77, 8'h88};
        send_frame(f, 0, 0, 1'b1);

        for (int fr = 0; fr < 30; fr++) begin
            f.delete();
            len = int'($urandom_range(3 * N, 1));
            for (int i = 0; i < len; i++) f.push_back(8'($urandom));
            send_frame(f, 0, (fr % 3 == 0) ? 0 : 2, 1'b1);
        end

        repeat (5) @(negedge clk);
        check("pending_words", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
